// File: rtl/mux_8_1_rr_sched_if.sv
// Bus bundle between the round-robin scheduler, the sources, mux_8_1 and
// the downstream consumer. The master side is the scheduler itself; the
// slave side is everything around it (sources, mux, consumer).
interface mux_8_1_rr_sched_if #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 8
);

  logic [N_CH-1:0]   req;
  logic [N_CH-1:0]   ack;
  logic [2:0]        sel;
  logic [DATA_W-1:0] mux_y;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        out_chan;
  logic              out_valid;
  logic              out_ready;

  modport master (
    input  req,
    output ack,
    output sel,
    input  mux_y,
    output out_data,
    output out_chan,
    output out_valid,
    input  out_ready
  );

  modport slave (
    output req,
    input  ack,
    input  sel,
    output mux_y,
    input  out_data,
    input  out_chan,
    input  out_valid,
    output out_ready
  );

endinterface

// File: rtl/mux_8_1_rr_sched.sv
// Round-robin scheduler wrapped around an 8:1 mux. It picks one requesting
// source, drives the mux select, captures the mux output one cycle later
// together with the channel tag, acknowledges the source and holds the word
// on a valid/ready output until the consumer takes it.
module mux_8_1_rr_sched #(
  parameter int DATA_W = 8,
  parameter int N_CH   = 8
) (
  input  logic               clk,
  input  logic               rst,
  mux_8_1_rr_sched_if.master bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_HOLD   = 2'd2;

  logic [1:0]        state_q,     state_d;
  logic [2:0]        sel_q,       sel_d;
  logic [2:0]        ptr_q,       ptr_d;
  logic [N_CH-1:0]   ack_q,       ack_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic [2:0]        out_chan_q,  out_chan_d;
  logic              out_valid_q, out_valid_d;

  logic              win_found;
  logic [2:0]        win_idx;
  logic [2:0]        cand;

  // Rotating priority search: first requesting channel at or after ptr, wrapping at 8.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int i = 0; i < N_CH; i++) begin
      cand = ptr_q + 3'(i);
      if (!win_found && bus.req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  // Next-state logic: IDLE grants, SETTLE captures and acks, HOLD waits for the handshake.
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    ptr_d       = ptr_q;
    ack_d       = '0;
    out_data_d  = out_data_q;
    out_chan_d  = out_chan_q;
    out_valid_d = out_valid_q;
    case (state_q)
      ST_IDLE: begin
        if (win_found) begin
          sel_d   = win_idx;
          state_d = ST_SETTLE;
        end
      end
      ST_SETTLE: begin
        out_data_d     = bus.mux_y;
        out_chan_d     = sel_q;
        out_valid_d    = 1'b1;
        ack_d[sel_q]   = 1'b1;
        ptr_d          = sel_q + 3'd1;
        state_d        = ST_HOLD;
      end
      ST_HOLD: begin
        if (out_valid_q && bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers with synchronous reset that overrides everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      sel_q       <= '0;
      ptr_q       <= '0;
      ack_q       <= '0;
      out_data_q  <= '0;
      out_chan_q  <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      ptr_q       <= ptr_d;
      ack_q       <= ack_d;
      out_data_q  <= out_data_d;
      out_chan_q  <= out_chan_d;
      out_valid_q <= out_valid_d;
    end
  end

  // Sanity check: at most one source is ever acknowledged at a time.
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert ($onehot0(ack_q));
    end
  end

  assign bus.sel       = sel_q;
  assign bus.ack       = ack_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_8_1_rr_sched.sv
// Directed testbench for mux_8_1_rr_sched with a behavioural 8:1 mux model.
module tb_mux_8_1_rr_sched;

  logic clk;
  logic rst;
  logic [7:0] mux_in [8];
  int tests_run;
  int tests_failed;

  mux_8_1_rr_sched_if #(.DATA_W(8), .N_CH(8)) bus ();

  mux_8_1_rr_sched #(.DATA_W(8), .N_CH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Combinational mux model: y follows sel immediately.
  assign bus.mux_y = mux_in[bus.sel];

  // Free-running clock, 10 time-unit period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout run=%0d failed=%0d", tests_run, tests_failed);
    $fatal(1, "[TB] watchdog expired");
  end

  // Advance one clock and settle just past the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic load_default_data();
    for (int k = 0; k < 8; k++) mux_in[k] = 8'h10 + 8'(k);
  endtask

  // Reset held with all sources requesting, then the first grant goes to channel 0.
  task automatic test_reset();
    rst = 1'b1;
    bus.req = 8'hFF;
    bus.out_ready = 1'b1;
    for (int c = 0; c < 2; c++) begin
      tick();
      tests_run++; if (bus.sel !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_sel got %0d exp 0", bus.sel); end
      tests_run++; if (bus.ack !== 8'h00) begin tests_failed++; $display("[TB] FAIL reset_ack got %h exp 00", bus.ack); end
      tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_valid got %b exp 0", bus.out_valid); end
    end
    rst = 1'b0;
    tick();
    tests_run++; if (bus.sel !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_first_sel got %0d exp 0", bus.sel); end
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_first_early_valid got %b exp 0", bus.out_valid); end
    tick();
    tests_run++; if (bus.ack !== 8'h01) begin tests_failed++; $display("[TB] FAIL reset_first_ack got %h exp 01", bus.ack); end
    tests_run++; if (bus.out_chan !== 3'd0) begin tests_failed++; $display("[TB] FAIL reset_first_chan got %0d exp 0", bus.out_chan); end
    tests_run++; if (bus.out_data !== 8'h10) begin tests_failed++; $display("[TB] FAIL reset_first_data got %h exp 10", bus.out_data); end
    bus.req = 8'h00;
    tick();
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_first_release got %b exp 0", bus.out_valid); end
  endtask

  // One source, custom mux data on its input.
  task automatic test_single();
    do_reset();
    mux_in[2] = 8'hA5;
    bus.req = 8'h04;
    tick();
    tests_run++; if (bus.sel !== 3'd2) begin tests_failed++; $display("[TB] FAIL single_sel got %0d exp 2", bus.sel); end
    tests_run++; if (bus.ack !== 8'h00) begin tests_failed++; $display("[TB] FAIL single_early_ack got %h exp 00", bus.ack); end
    tick();
    tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL single_valid got %b exp 1", bus.out_valid); end
    tests_run++; if (bus.out_data !== 8'hA5) begin tests_failed++; $display("[TB] FAIL single_data got %h exp a5", bus.out_data); end
    tests_run++; if (bus.out_chan !== 3'd2) begin tests_failed++; $display("[TB] FAIL single_chan got %0d exp 2", bus.out_chan); end
    tests_run++; if (bus.ack !== 8'h04) begin tests_failed++; $display("[TB] FAIL single_ack got %h exp 04", bus.ack); end
    bus.req = 8'h00;
    tick();
    tests_run++; if (bus.ack !== 8'h00) begin tests_failed++; $display("[TB] FAIL single_ack_len got %h exp 00", bus.ack); end
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL single_release got %b exp 0", bus.out_valid); end
    load_default_data();
  endtask

  // All sources requesting: grants rotate 0..7 then 0, one word every 3 cycles.
  task automatic test_round_robin();
    int pending;
    logic [2:0] ch;
    do_reset();
    pending = -1;
    bus.req = 8'hFF;
    for (int g = 0; g < 9; g++) begin
      ch = 3'(g % 8);
      tick();
      tests_run++; if (bus.sel !== ch) begin tests_failed++; $display("[TB] FAIL rr_sel[%0d] got %0d exp %0d", g, bus.sel, ch); end
      tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rr_gap_valid[%0d] got %b exp 0", g, bus.out_valid); end
      if (pending >= 0) bus.req[pending] = 1'b1;
      tick();
      tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL rr_valid[%0d] got %b exp 1", g, bus.out_valid); end
      tests_run++; if (bus.out_chan !== ch) begin tests_failed++; $display("[TB] FAIL rr_chan[%0d] got %0d exp %0d", g, bus.out_chan, ch); end
      tests_run++; if (bus.out_data !== 8'h10 + 8'(ch)) begin tests_failed++; $display("[TB] FAIL rr_data[%0d] got %h exp %h", g, bus.out_data, 8'h10 + 8'(ch)); end
      tests_run++; if (bus.ack !== (8'h01 << ch)) begin tests_failed++; $display("[TB] FAIL rr_ack[%0d] got %h exp %h", g, bus.ack, 8'h01 << ch); end
      bus.req[ch] = 1'b0;
      pending = int'(ch);
      tick();
      tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rr_handshake[%0d] got %b exp 0", g, bus.out_valid); end
    end
    bus.req = 8'h00;
    tick();
  endtask

  // Consumer stalls: output and select frozen, ack not repeated, then order resumes.
  task automatic test_backpressure();
    do_reset();
    bus.out_ready = 1'b0;
    bus.req = 8'h0A;
    tick();
    tests_run++; if (bus.sel !== 3'd1) begin tests_failed++; $display("[TB] FAIL bp_sel got %0d exp 1", bus.sel); end
    tick();
    tests_run++; if (bus.ack !== 8'h02) begin tests_failed++; $display("[TB] FAIL bp_ack got %h exp 02", bus.ack); end
    bus.req[1] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      tick();
      tests_run++; if (bus.out_valid !== 1'b1) begin tests_failed++; $display("[TB] FAIL bp_hold_valid[%0d] got %b exp 1", c, bus.out_valid); end
      tests_run++; if (bus.out_data !== 8'h11) begin tests_failed++; $display("[TB] FAIL bp_hold_data[%0d] got %h exp 11", c, bus.out_data); end
      tests_run++; if (bus.out_chan !== 3'd1) begin tests_failed++; $display("[TB] FAIL bp_hold_chan[%0d] got %0d exp 1", c, bus.out_chan); end
      tests_run++; if (bus.sel !== 3'd1) begin tests_failed++; $display("[TB] FAIL bp_hold_sel[%0d] got %0d exp 1", c, bus.sel); end
      tests_run++; if (bus.ack !== 8'h00) begin tests_failed++; $display("[TB] FAIL bp_hold_ack[%0d] got %h exp 00", c, bus.ack); end
    end
    bus.out_ready = 1'b1;
    tick();
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL bp_handshake got %b exp 0", bus.out_valid); end
    tick();
    tests_run++; if (bus.sel !== 3'd3) begin tests_failed++; $display("[TB] FAIL bp_next_sel got %0d exp 3", bus.sel); end
    tick();
    tests_run++; if (bus.out_chan !== 3'd3) begin tests_failed++; $display("[TB] FAIL bp_next_chan got %0d exp 3", bus.out_chan); end
    tests_run++; if (bus.out_data !== 8'h13) begin tests_failed++; $display("[TB] FAIL bp_next_data got %h exp 13", bus.out_data); end
    tests_run++; if (bus.ack !== 8'h08) begin tests_failed++; $display("[TB] FAIL bp_next_ack got %h exp 08", bus.ack); end
    bus.req = 8'h00;
    tick();
  endtask

  // Pointer at 7 must grant channel 7 before wrapping to channel 0.
  task automatic test_wraparound();
    do_reset();
    bus.req = 8'h40;
    tick();
    tick();
    tests_run++; if (bus.out_chan !== 3'd6) begin tests_failed++; $display("[TB] FAIL wrap_first_chan got %0d exp 6", bus.out_chan); end
    bus.req = 8'h00;
    tick();
    bus.req = 8'h81;
    tick();
    tests_run++; if (bus.sel !== 3'd7) begin tests_failed++; $display("[TB] FAIL wrap_sel7 got %0d exp 7", bus.sel); end
    tick();
    tests_run++; if (bus.ack !== 8'h80) begin tests_failed++; $display("[TB] FAIL wrap_ack7 got %h exp 80", bus.ack); end
    tests_run++; if (bus.out_data !== 8'h17) begin tests_failed++; $display("[TB] FAIL wrap_data7 got %h exp 17", bus.out_data); end
    bus.req = 8'h01;
    tick();
    tick();
    tests_run++; if (bus.sel !== 3'd0) begin tests_failed++; $display("[TB] FAIL wrap_sel0 got %0d exp 0", bus.sel); end
    tick();
    tests_run++; if (bus.ack !== 8'h01) begin tests_failed++; $display("[TB] FAIL wrap_ack0 got %h exp 01", bus.ack); end
    tests_run++; if (bus.out_chan !== 3'd0) begin tests_failed++; $display("[TB] FAIL wrap_chan0 got %0d exp 0", bus.out_chan); end
    bus.req = 8'h00;
    tick();
  endtask

  // Reset during SETTLE abandons the transfer and returns the pointer to 0.
  task automatic test_reset_mid();
    do_reset();
    bus.req = 8'h08;
    tick();
    tick();
    bus.req = 8'h00;
    tick();
    bus.req = 8'hFF;
    tick();
    tests_run++; if (bus.sel !== 3'd4) begin tests_failed++; $display("[TB] FAIL mid_pre_sel got %0d exp 4", bus.sel); end
    rst = 1'b1;
    tick();
    tests_run++; if (bus.ack !== 8'h00) begin tests_failed++; $display("[TB] FAIL mid_ack got %h exp 00", bus.ack); end
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_valid got %b exp 0", bus.out_valid); end
    tests_run++; if (bus.sel !== 3'd0) begin tests_failed++; $display("[TB] FAIL mid_sel got %0d exp 0", bus.sel); end
    rst = 1'b0;
    tick();
    tests_run++; if (bus.sel !== 3'd0) begin tests_failed++; $display("[TB] FAIL mid_regrant_sel got %0d exp 0", bus.sel); end
    tests_run++; if (bus.out_valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL mid_regrant_valid got %b exp 0", bus.out_valid); end
    tick();
    tests_run++; if (bus.ack !== 8'h01) begin tests_failed++; $display("[TB] FAIL mid_regrant_ack got %h exp 01", bus.ack); end
    tests_run++; if (bus.out_chan !== 3'd0) begin tests_failed++; $display("[TB] FAIL mid_regrant_chan got %0d exp 0", bus.out_chan); end
    bus.req = 8'h00;
    tick();
  endtask

  // Test sequence.
  initial begin
    tests_run = 0;
    tests_failed = 0;
    rst = 1'b1;
    bus.req = '0;
    bus.out_ready = 1'b1;
    load_default_data();
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_wraparound();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
